// File: rtl/ty_stream_pkg.sv
// Shared definitions for the TyTra fifo stream reader: occupancy encoding
// and default data/length widths.
package ty_stream_pkg;

  localparam int DBITS_DEFAULT = 32;
  localparam int LBITS_DEFAULT = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/ty_stream_skid_buf.sv
// Two-entry {last,data} output buffer. The head entry drives the stream
// outputs straight from registers; the skid entry absorbs one extra word.
module ty_stream_skid_buf
  import ty_stream_pkg::*;
#(
  parameter int dbits = DBITS_DEFAULT
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [dbits-1:0] push_data,
  input  logic             push_last,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [dbits-1:0] out_data,
  output logic             out_last,
  output logic             pop,
  output logic             full
);

  occ_e             state_q, state_d;
  logic [dbits-1:0] head_data_q, head_data_d;
  logic [dbits-1:0] skid_data_q, skid_data_d;
  logic             head_last_q, head_last_d;
  logic             skid_last_q, skid_last_d;

  assign out_valid = (state_q != OCC_EMPTY);
  assign pop       = out_valid & out_ready;
  assign full      = (state_q == OCC_TWO);
  assign out_data  = head_data_q;
  assign out_last  = head_last_q;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    case (state_q)
      OCC_EMPTY: begin
        if (push) begin
          state_d     = OCC_ONE;
          head_data_d = push_data;
          head_last_d = push_last;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          // pass-through: the new word replaces the departing head
          head_data_d = push_data;
          head_last_d = push_last;
        end else if (push) begin
          state_d     = OCC_TWO;
          skid_data_d = push_data;
          skid_last_d = push_last;
        end else if (pop) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          state_d     = OCC_ONE;
          head_data_d = skid_data_q;
          head_last_d = skid_last_q;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= OCC_EMPTY;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
    end
  end

endmodule

// File: rtl/ty_fifo_stream_reader.sv
// Drains a TyTra fifo core into an AXI-stream master, tagging tlast from a
// runtime packet length and counting accepted beats.
module ty_fifo_stream_reader
  import ty_stream_pkg::*;
#(
  parameter int dbits = DBITS_DEFAULT,
  parameter int lbits = LBITS_DEFAULT
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [dbits-1:0] fifo_dout,
  input  logic [lbits-1:0] pkt_len,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [dbits-1:0] m_tdata,
  output logic             m_tlast,
  output logic [lbits-1:0] beats_out
);

  logic             full;
  logic             pop;
  logic             tag_last;
  logic [lbits-1:0] len_eff;
  logic [lbits-1:0] cnt_q, cnt_d;
  logic [lbits-1:0] pkt_len_q, pkt_len_d;
  logic [lbits-1:0] beats_q, beats_d;

  // Read decision uses only registered occupancy, never m_tready.
  assign fifo_rd   = resetn & ~fifo_empty & ~full;
  assign beats_out = beats_q;

  always_comb begin
    len_eff   = (cnt_q == '0) ? pkt_len : pkt_len_q;
    tag_last  = (len_eff != '0) && (cnt_q == len_eff - lbits'(1));
    cnt_d     = cnt_q;
    pkt_len_d = pkt_len_q;
    beats_d   = pop ? beats_q + lbits'(1) : beats_q;
    if (fifo_rd) begin
      pkt_len_d = len_eff;
      cnt_d     = tag_last ? '0 : cnt_q + lbits'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      pkt_len_q <= '0;
      beats_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pkt_len_q <= pkt_len_d;
      beats_q   <= beats_d;
    end
  end

  ty_stream_skid_buf #(
    .dbits(dbits)
  ) u_buf (
    .clock     (clock),
    .resetn    (resetn),
    .push      (fifo_rd),
    .push_data (fifo_dout),
    .push_last (tag_last),
    .out_ready (m_tready),
    .out_valid (m_tvalid),
    .out_data  (m_tdata),
    .out_last  (m_tlast),
    .pop       (pop),
    .full      (full)
  );

endmodule
